// File: rtl/dmem_arbiter_if.sv
// dmem_req_if: one requester's valid/ready bus toward the data-memory arbiter.
//   master modport : used by the requester (core or loader)
//   slave modport  : used by the arbiter
// Signals:
//   valid/ready    request handshake, accepted when both are high
//   we             1 = write, 0 = read
//   addr/wdata/be  byte address, write data, byte enables
//   rvalid/rdata   registered read response, one cycle after acceptance
`timescale 1ns/1ps
interface dmem_req_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            valid;
  logic            ready;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output valid, we, addr, wdata, be,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, be,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core data port (m0) and the
// debug/loader port (m1). Round-robin per-cycle arbitration, with a bounded
// priority lock that the loader can request for bursts.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low (0 = in reset)
//   m0, m1     requester buses (dmem_req_if.slave)
//   m1_lock    loader asks for priority / burst lock
//   mem_we, mem_addr, mem_wdata, mem_be   request toward dmem
//   mem_rdata  combinational read data from dmem
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_req_if.slave       m0,
  dmem_req_if.slave       m1,
  input  logic            m1_lock,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

  logic       grant0;
  logic       grant1;
  logic       last_grant;
  logic [3:0] lock_cnt;

  // Grants are blocked while reset is held so that ready and the dmem
  // request fall to idle immediately, and a half-issued write never commits.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      if (m0.valid && !m1.valid) begin
        grant0 = 1'b1;
      end else if (m1.valid && !m0.valid) begin
        grant1 = 1'b1;
      end else if (m0.valid && m1.valid) begin
        if (m1_lock && (lock_cnt < MAX_CNT)) begin
          grant1 = 1'b1;
        end else if (last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end
    end
  end

  assign m0.ready = grant0;
  assign m1.ready = grant1;

  // Winner's request goes straight to dmem; an idle cycle drives all zeros.
  // A write with no byte enabled still handshakes but never strobes dmem.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant0) begin
      mem_we    = m0.we & (|m0.be);
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
      mem_be    = m0.be;
    end else if (grant1) begin
      mem_we    = m1.we & (|m1.be);
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
      mem_be    = m1.be;
    end
  end

  // Round-robin pointer, lock counter and the one-cycle read response.
  // lock_cnt only counts loader grants that actually made the core wait;
  // once it saturates the lock rule stops applying and round-robin hands the
  // next contended cycle to the core, which clears the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      m0.rvalid  <= 1'b0;
      m0.rdata   <= '0;
      m1.rvalid  <= 1'b0;
      m1.rdata   <= '0;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end

      if (grant0 || !m1_lock) begin
        lock_cnt <= '0;
      end else if (grant1 && m0.valid && (lock_cnt < MAX_CNT)) begin
        lock_cnt <= lock_cnt + 4'd1;
      end

      m0.rvalid <= grant0 & ~m0.we;
      m1.rvalid <= grant1 & ~m1.we;
      if (grant0 && !m0.we) begin
        m0.rdata <= mem_rdata;
      end
      if (grant1 && !m1.we) begin
        m1.rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter.
// A small word-addressed memory model sits on the dmem side; every expected
// value below is a hand-computed constant.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m1_lock;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        preload;

  int num_compared;
  int num_mismatched;

  logic [31:0] mem [0:255];

  dmem_req_if #(.AW(32), .DW(32)) m0_bus ();
  dmem_req_if #(.AW(32), .DW(32)) m1_bus ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .m1_lock   (m1_lock),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read, byte-enabled write memory model (index = addr[9:2]).
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      mem[16] <= 32'hDEADBEEF;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    if (port == 0) begin
      m0_bus.valid = valid;
      m0_bus.we    = we;
      m0_bus.addr  = addr;
      m0_bus.wdata = wdata;
      m0_bus.be    = be;
    end else begin
      m1_bus.valid = valid;
      m1_bus.we    = we;
      m1_bus.addr  = addr;
      m1_bus.wdata = wdata;
      m1_bus.be    = be;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] lock_pattern;
    num_compared   = 0;
    num_mismatched = 0;
    reset   = 1'b0;
    preload = 1'b1;
    m1_lock = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h8, 32'h55, 4'hF);

    // Reset state, with both requesters pushing
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_m0_ready",  {31'd0, m0_bus.ready},  32'd0);
    checkOutput("rst_m1_ready",  {31'd0, m1_bus.ready},  32'd0);
    checkOutput("rst_m0_rvalid", {31'd0, m0_bus.rvalid}, 32'd0);
    checkOutput("rst_m1_rvalid", {31'd0, m1_bus.rvalid}, 32'd0);
    checkOutput("rst_m0_rdata",  m0_bus.rdata,           32'd0);
    checkOutput("rst_mem_we",    {31'd0, mem_we},        32'd0);
    checkOutput("rst_mem_addr",  mem_addr,               32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,              32'd0);

    // 1: contended reads alternate, core first
    nextCycle();
    preload = 1'b0;
    reset   = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_m0_ready[%0d]", i), {31'd0, m0_bus.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_m1_ready[%0d]", i), {31'd0, m1_bus.ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        checkOutput($sformatf("rr_m0_rvalid[%0d]", i), {31'd0, m0_bus.rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        checkOutput($sformatf("rr_m1_rvalid[%0d]", i), {31'd0, m1_bus.rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      nextCycle();
    end

    // 2: single read of 0x40, response next cycle only
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_m0_ready", {31'd0, m0_bus.ready}, 32'd1);
    checkOutput("rd_mem_addr", mem_addr, 32'h40);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_m0_rvalid", {31'd0, m0_bus.rvalid}, 32'd1);
    checkOutput("rd_m0_rdata",  m0_bus.rdata, 32'hDEADBEEF);
    checkOutput("rd_m1_rvalid", {31'd0, m1_bus.rvalid}, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rd_m0_rvalid_off", {31'd0, m0_bus.rvalid}, 32'd0);
    checkOutput("rd_m0_rdata_hold", m0_bus.rdata, 32'hDEADBEEF);

    // 3: loader write 0x100, then core reads it back
    nextCycle();
    applyStimulus(1, 1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF);
    @(negedge clk);
    checkOutput("wr_m1_ready",  {31'd0, m1_bus.ready}, 32'd1);
    checkOutput("wr_mem_we",    {31'd0, mem_we}, 32'd1);
    checkOutput("wr_mem_addr",  mem_addr, 32'h100);
    checkOutput("wr_mem_wdata", mem_wdata, 32'h12345678);
    checkOutput("wr_mem_be",    {28'd0, mem_be}, 32'hF);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("wr_m1_no_rvalid", {31'd0, m1_bus.rvalid}, 32'd0);
    checkOutput("wr_m0_ready",     {31'd0, m0_bus.ready}, 32'd1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("wr_readback_rvalid", {31'd0, m0_bus.rvalid}, 32'd1);
    checkOutput("wr_readback_rdata",  m0_bus.rdata, 32'h12345678);

    // 4: locked bursts: m1 x4, m0, m1 x4, m0; then plain alternation
    nextCycle();
    m1_lock = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    lock_pattern = 10'b0111101111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("lock_m1_ready[%0d]", i), {31'd0, m1_bus.ready}, {31'd0, lock_pattern[i]});
      checkOutput($sformatf("lock_m0_ready[%0d]", i), {31'd0, m0_bus.ready}, {31'd0, ~lock_pattern[i]});
      nextCycle();
    end
    m1_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("unlock_m1_ready[%0d]", i), {31'd0, m1_bus.ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      nextCycle();
    end

    // 5: core write with no byte enables is a no-op that still handshakes
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'h0);
    @(negedge clk);
    checkOutput("be0_m0_ready", {31'd0, m0_bus.ready}, 32'd1);
    checkOutput("be0_mem_we",   {31'd0, mem_we}, 32'd0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("be0_no_rvalid", {31'd0, m0_bus.rvalid}, 32'd0);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("be0_mem_unchanged", m0_bus.rdata, 32'hDEADBEEF);

    // 6: reset asserted after a read is accepted, before its response edge
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("mid_m0_ready", {31'd0, m0_bus.ready}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_ready_drop", {31'd0, m0_bus.ready}, 32'd0);
    checkOutput("mid_mem_addr",   mem_addr, 32'd0);
    checkOutput("mid_rdata_clr",  m0_bus.rdata, 32'd0);
    nextCycle();
    checkOutput("mid_no_rvalid",  {31'd0, m0_bus.rvalid}, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("restart_m0_first", {31'd0, m0_bus.ready}, 32'd1);
    checkOutput("restart_m1_wait",  {31'd0, m1_bus.ready}, 32'd0);

    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (dmem) between two requesters: port 0 is the ARM core data port, port 1 is the debug/loader (DMA) port.
- Per-cycle round-robin arbitration with valid/ready handshakes.
- Requester 1 can request a bounded lock for back-to-back bursts.
- Read data is returned registered, one cycle after acceptance. The block sits between the core/loader and dmem at top level.

Parameters:
- AW, 32, address width.
- DW, 32, data width. BE width is DW/8.
- MAX_LOCK, 4, maximum consecutive port-1 grants under lock while port 0 is waiting. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- m0_valid  in  1  core request valid.
- m0_ready  out  1  core request accepted this cycle.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  AW  byte address.
- m0_wdata  in  DW  write data.
- m0_be  in  DW/8  byte enables.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DW  read data.
- m1_valid, m1_ready, m1_we, m1_addr, m1_wdata, m1_be, m1_rvalid, m1_rdata: same as port 0, for the loader.
- m1_lock  in  1  loader requests priority/burst lock.
- mem_we  out  1  dmem write enable.
- mem_addr  out  AW  dmem address.
- mem_wdata  out  DW  dmem write data.
- mem_be  out  DW/8  dmem byte enables.
- mem_rdata  in  DW  dmem combinational read data.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: m*_ready 0, m*_rvalid 0, m*_rdata 0, mem_we 0, mem_addr/wdata/be 0, last_grant = 1 (port 0 wins the first tie), lock_cnt 0.
- Grant decision is combinational each cycle. m*_ready = grant to that port. At most one ready is high per cycle.
- Grant rules, applied in order:
  a) Neither port valid: no grant; mem_* = 0, mem_we = 0.
  b) Only one port valid: grant that port.
  c) Both valid, m1_lock = 1, lock_cnt < MAX_LOCK: grant port 1.
  d) Both valid otherwise: grant the port not in last_grant (round-robin).
- last_grant updates on every grant.
- lock_cnt:
  - Increments on a port-1 grant while m1_lock = 1 and m0_valid = 1.
  - Clears on any port-0 grant, or when m1_lock = 0.
  - Saturates at MAX_LOCK.
  - Reaching MAX_LOCK forces the next contended cycle to port 0 (via rule d).
- The accepted request is muxed combinationally onto mem_addr/mem_wdata/mem_be.
- mem_we = grant & we & (be != 0).
- Write commits at the rising edge that ends the accept cycle.
- Write with be == 0: handshake completes, mem_we stays 0, no memory change, no rvalid.
- Read accepted in cycle N: mem_rdata is captured at the end of N. That port's rvalid = 1 with rdata in cycle N+1 only, for a single cycle.
- Throughput is 1 access/cycle. Back-to-back reads on alternating ports give alternating rvalid.
- rdata holds its last value when rvalid = 0.
- Writes produce no rvalid.
- Requesters must hold addr/we/wdata/be stable while valid & !ready. The arbiter does not check this.
- No address decoding or alignment checks: the address passes through unchanged.
- Reset asserted mid-operation: pending rvalid is cleared immediately (asynchronous) and any uncommitted write is dropped. After release, the arbiter restarts from the reset state.

Test Plan:
1. Release reset; both ports assert read continuously -> grants m0, m1, m0, m1; m0_ready first.
2. m0 read addr 0x40, mem_rdata = 0xDEADBEEF -> m0_rvalid = 1 and m0_rdata = 0xDEADBEEF in the next cycle only; m1_rvalid = 0.
3. m1 write addr 0x100, wdata 0x12345678, be 0xF -> mem_we = 1 in the accept cycle; a following m0 read of 0x100 returns 0x12345678.
4. MAX_LOCK = 4, m1_lock = 1, both valid continuously -> grant sequence m1 x4, m0, m1 x4, m0. With m1_lock = 0 the sequence reverts to strict alternation.
5. m0 write with be = 0x0 -> m0_ready = 1, mem_we = 0, memory unchanged, no rvalid.
6. m0 read accepted, then reset pulled low before the next edge -> m0_rvalid stays 0 and all outputs return to reset values immediately.
